// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS IF stage: PC register, next-PC select, fetch fault, perf counters
//
// Owns the architectural PC of the 5-stage pipeline and presents {if_pc, if_instr}
// to the IF/ID register. Next-PC selection uses the branch/jump resolution made in ID,
// so the instruction behind a branch (its delay slot) is always fetched and never squashed.
//
// Parameters
//   RESET_PC   PC value loaded on reset
//   IM_BASE    lowest legal fetch address
//   IM_WORDS   instruction-memory depth in words
//
// Ports
//   clk            in   1   clock, rising edge
//   reset          in   1   synchronous, active-high; overrides stall and redirect
//   stall          in   1   hazard-unit stall; PC holds and redirect is ignored
//   npc_sel        in   2   00 seq, 01 cond branch, 10 j/jal, 11 jr/jalr
//   br_taken       in   1   branch comparator result, used only with npc_sel=01
//   id_pc          in   32  PC of the instruction in ID
//   id_instr       in   32  instruction in ID (imm16 = [15:0], imm26 = [25:0])
//   id_rs_val      in   32  forwarded rs value, jr/jalr target
//   im_addr        out  32  instruction-memory address (= if_pc)
//   im_rdata       in   32  instruction word, combinational read of im_addr
//   if_pc          out  32  PC of the instruction being fetched
//   if_instr       out  32  fetched instruction, nop when fetch_fault
//   fetch_fault    out  1   PC misaligned or outside instruction memory
//   cnt_fetch      out  32  cycles in which the PC advanced
//   cnt_stall      out  32  cycles with stall asserted
//   cnt_redirect   out  32  cycles in which a non-sequential target was loaded

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_val,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault,
    output logic [31:0] cnt_fetch,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_redirect
);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JREG   = 2'b11;

    // Highest legal word address; computed in 33 bits so a memory ending at the
    // top of the address space cannot wrap the bound.
    localparam logic [32:0] IM_LAST = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4 - 33'd4;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] cnt_fetch_q;
    logic [31:0] cnt_fetch_d;
    logic [31:0] cnt_stall_q;
    logic [31:0] cnt_stall_d;
    logic [31:0] cnt_redirect_q;
    logic [31:0] cnt_redirect_d;

    logic [31:0] pc_plus4;
    logic [31:0] id_pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc;
    logic        redirect;

    // ------------------------------------------------------------------
    // Target arithmetic (all modulo 2^32)
    // ------------------------------------------------------------------
    assign pc_plus4    = pc_q + 32'd4;
    assign id_pc_plus4 = id_pc + 32'd4;
    assign br_offset   = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    assign br_target   = id_pc_plus4 + br_offset;
    assign j_target    = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};

    // An untaken conditional branch is plain sequential flow and is not a redirect.
    always_comb begin
        npc      = pc_plus4;
        redirect = 1'b0;
        case (npc_sel)
            SEL_SEQ: begin
                npc      = pc_plus4;
                redirect = 1'b0;
            end
            SEL_BRANCH: begin
                if (br_taken) begin
                    npc      = br_target;
                    redirect = 1'b1;
                end
            end
            SEL_JUMP: begin
                npc      = j_target;
                redirect = 1'b1;
            end
            SEL_JREG: begin
                // No alignment masking: a bad register target is loaded and
                // shows up as fetch_fault on the following cycle.
                npc      = id_rs_val;
                redirect = 1'b1;
            end
            default: begin
                npc      = pc_plus4;
                redirect = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state for PC and counters; stall freezes the PC and discards the
    // redirect since ID re-presents the same control-flow instruction.
    // ------------------------------------------------------------------
    assign pc_d           = stall ? pc_q : npc;
    assign cnt_fetch_d    = stall ? cnt_fetch_q : cnt_fetch_q + 32'd1;
    assign cnt_stall_d    = stall ? cnt_stall_q + 32'd1 : cnt_stall_q;
    assign cnt_redirect_d = (!stall && redirect) ? cnt_redirect_q + 32'd1 : cnt_redirect_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            cnt_fetch_q    <= 32'd0;
            cnt_stall_q    <= 32'd0;
            cnt_redirect_q <= 32'd0;
        end else begin
            pc_q           <= pc_d;
            cnt_fetch_q    <= cnt_fetch_d;
            cnt_stall_q    <= cnt_stall_d;
            cnt_redirect_q <= cnt_redirect_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch path: purely combinational from the PC register
    // ------------------------------------------------------------------
    logic misaligned;
    logic out_of_range;

    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign out_of_range = (pc_q < IM_BASE) || ({1'b0, pc_q} > IM_LAST);

    assign fetch_fault  = misaligned || out_of_range;
    assign im_addr      = pc_q;
    assign if_pc        = pc_q;
    assign if_instr     = fetch_fault ? 32'h0000_0000 : im_rdata;

    assign cnt_fetch    = cnt_fetch_q;
    assign cnt_stall    = cnt_stall_q;
    assign cnt_redirect = cnt_redirect_q;

endmodule
